mouse_event_ctl: RTL and testbench

Controller that sits after the mouse buffer stage in the clk40 pixel domain and turns raw cursor position and left-button level into clean, screen-bounded events for game/UI logic. It clamps coordinates to the visible area and debounces the button. A press/drag state machine classifies each gesture. Results go out through a one-deep valid/ready event port, so consumers never sample the raw mouse signals directly.

---
 rtl/mouse_event_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_mouse_event_ctl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_event_ctl.sv
// Mouse event controller: clamps the cursor, debounces the left button, classifies click/drag gestures.
// Optional drag detection is enabled by defining MOUSE_DRAG_EN; without it every gesture is a CLICK.
module mouse_event_ctl #(
    parameter logic [11:0] H_MAX        = 12'd799,
    parameter logic [11:0] V_MAX        = 12'd599,
`ifdef MOUSE_DRAG_EN
    parameter int unsigned DRAG_THRESH  = 32'd4,
`endif
    parameter int unsigned DEBOUNCE_CYC = 32'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos_in,
    input  logic [11:0] ypos_in,
    input  logic        left_in,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [11:0] evt_x,
    output logic [11:0] evt_y,
    output logic        drag_active,
    output logic        evt_drop
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [1:0] EVT_CLICK = 2'b00;
`ifdef MOUSE_DRAG_EN
    localparam logic [1:0] EVT_DRAG_START = 2'b01;
    localparam logic [1:0] EVT_DRAG_END   = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_DRAG    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               left_s;
    logic               btn_db_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [11:0]        px_r;
    logic [11:0]        py_r;
    logic               latch_s;
    logic               emit_s;
    logic [1:0]         emit_type_s;
    logic [11:0]        emit_x_s;
    logic [11:0]        emit_y_s;

    // Clamp the cursor to the visible area.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xpos <= 12'd0;
            ypos <= 12'd0;
        end else begin
            xpos <= (xpos_in > H_MAX) ? H_MAX : xpos_in;
            ypos <= (ypos_in > V_MAX) ? V_MAX : ypos_in;
        end
    end

    // Button debounce: accept a new level only after it has been stable long enough.
    always_ff @(posedge clk) begin
        if (!rst) begin
            left_s   <= 1'b0;
            btn_db_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            left_s <= left_in;
            if (left_s != btn_db_r) begin
                if (cnt_r == CNT_W'(DEBOUNCE_CYC - 32'd1)) begin
                    btn_db_r <= left_s;
                    cnt_r    <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

`ifdef MOUSE_DRAG_EN
    logic [12:0] dx_s;
    logic [12:0] dy_s;
    logic        moved_s;

    // Displacement of the clamped cursor from the press point.
    always_comb begin
        dx_s = (xpos >= px_r) ? ({1'b0, xpos} - {1'b0, px_r}) : ({1'b0, px_r} - {1'b0, xpos});
        dy_s = (ypos >= py_r) ? ({1'b0, ypos} - {1'b0, py_r}) : ({1'b0, py_r} - {1'b0, ypos});
        moved_s = (dx_s > 13'(DRAG_THRESH)) || (dy_s > 13'(DRAG_THRESH));
    end
`endif

    // Gesture FSM next-state and event generation; release takes priority over movement.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        emit_s      = 1'b0;
        emit_type_s = EVT_CLICK;
        emit_x_s    = px_r;
        emit_y_s    = py_r;
        case (state_r)
            S_IDLE: begin
                if (btn_db_r) begin
                    latch_s = 1'b1;
                    state_s = S_PRESSED;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRESSED: begin
                if (!btn_db_r) begin
                    emit_s  = 1'b1;
                    state_s = S_IDLE;
                end
`ifdef MOUSE_DRAG_EN
                else if (moved_s) begin
                    emit_s      = 1'b1;
                    emit_type_s = EVT_DRAG_START;
                    state_s     = S_DRAG;
                end
`endif
                else begin
                    state_s = S_PRESSED;
                end
            end
`ifdef MOUSE_DRAG_EN
            S_DRAG: begin
                if (!btn_db_r) begin
                    emit_s      = 1'b1;
                    emit_type_s = EVT_DRAG_END;
                    emit_x_s    = xpos;
                    emit_y_s    = ypos;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_DRAG;
                end
            end
`endif
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FSM state and press-point registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            px_r    <= 12'd0;
            py_r    <= 12'd0;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                px_r <= xpos;
                py_r <= ypos;
            end
        end
    end

`ifdef MOUSE_DRAG_EN
    // drag_active tracks the DRAG state so it moves in step with the DRAG_START/DRAG_END events.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drag_active <= 1'b0;
        end else begin
            drag_active <= (state_s == S_DRAG);
        end
    end
`else
    assign drag_active = 1'b0;
`endif

    // One-deep event register; a new event arriving while the held one is stalled is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_type  <= 2'b00;
            evt_x     <= 12'd0;
            evt_y     <= 12'd0;
            evt_drop  <= 1'b0;
        end else if (emit_s) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_type  <= emit_type_s;
                evt_x     <= emit_x_s;
                evt_y     <= emit_y_s;
                evt_drop  <= 1'b0;
            end else begin
                evt_drop <= 1'b1;
            end
        end else begin
            evt_drop <= 1'b0;
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end else begin
                evt_valid <= evt_valid;
            end
        end
    end

endmodule

// File: tb/tb_mouse_event_ctl.sv
// Directed self-checking bench for mouse_event_ctl (default DEBOUNCE_CYC=16, DRAG_THRESH=4).
module tb_mouse_event_ctl;

    logic        clk;
    logic        rst;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        left_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_type;
    logic [11:0] evt_x;
    logic [11:0] evt_y;
    logic        drag_active;
    logic        evt_drop;

    int vectors;
    int miscompares;

    mouse_event_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .xpos_in     (xpos_in),
        .ypos_in     (ypos_in),
        .left_in     (left_in),
        .xpos        (xpos),
        .ypos        (ypos),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_type    (evt_type),
        .evt_x       (evt_x),
        .evt_y       (evt_y),
        .drag_active (drag_active),
        .evt_drop    (evt_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns the number of edges until evt_valid is seen, or -1 when the budget runs out.
    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            tick();
            cyc++;
            if (evt_valid) break;
        end
        if (!evt_valid) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0; xpos_in = 12'd1000; ypos_in = 12'd700; left_in = 1'b1; evt_ready = 1'b1;
        ticks(3);
        vectors++;
        if ({xpos, ypos, evt_x, evt_y} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_coords: got x=%0d y=%0d ex=%0d ey=%0d, want all 0", xpos, ypos, evt_x, evt_y);
        end
        vectors++;
        if ({evt_valid, evt_type, drag_active, evt_drop} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got v=%b t=%b da=%b drop=%b, want 0", evt_valid, evt_type, drag_active, evt_drop);
        end
        left_in = 1'b0; rst = 1'b1;
        tick();
        vectors++;
        if (xpos !== 12'd799 || ypos !== 12'd599) begin
            miscompares++;
            $display("FAIL clamp_max: got (%0d,%0d), want (799,599)", xpos, ypos);
        end
        xpos_in = 12'd100; ypos_in = 12'd600;
        tick();
        vectors++;
        if (xpos !== 12'd100 || ypos !== 12'd599) begin
            miscompares++;
            $display("FAIL clamp_pass: got (%0d,%0d), want (100,599)", xpos, ypos);
        end
        xpos_in = 12'd799; ypos_in = 12'd598;
        tick();
        vectors++;
        if (xpos !== 12'd799 || ypos !== 12'd598) begin
            miscompares++;
            $display("FAIL clamp_edge: got (%0d,%0d), want (799,598)", xpos, ypos);
        end
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        left_in = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (evt_valid || drag_active) seen++; end
        left_in = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(); if (evt_valid || drag_active) seen++; end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL glitch: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_click();
        int seen;
        int cyc;
        seen = 0;
        xpos_in = 12'd200; ypos_in = 12'd150; evt_ready = 1'b1;
        ticks(2);
        left_in = 1'b1;
        for (int i = 0; i < 40; i++) begin tick(); if (evt_valid) seen++; end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL click_press_quiet: got %0d valid cycles, want 0", seen);
        end
        left_in = 1'b0;
        wait_valid(40, cyc);
        vectors++;
        if (cyc !== 18) begin
            miscompares++;
            $display("FAIL click_latency: got %0d edges, want 18", cyc);
        end
        vectors++;
        if (evt_type !== 2'b00 || evt_x !== 12'd200 || evt_y !== 12'd150) begin
            miscompares++;
            $display("FAIL click_event: got t=%b (%0d,%0d), want 00 (200,150)", evt_type, evt_x, evt_y);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (evt_valid) seen++; end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL click_single: got %0d extra valid cycles, want 0", seen);
        end
    endtask

`ifdef MOUSE_DRAG_EN
    task automatic test_drag();
        int cyc;
        xpos_in = 12'd200; ypos_in = 12'd150; evt_ready = 1'b1;
        ticks(2);
        left_in = 1'b1;
        ticks(22);
        xpos_in = 12'd204;
        ticks(4);
        vectors++;
        if (evt_valid !== 1'b0 || drag_active !== 1'b0) begin
            miscompares++;
            $display("FAIL drag_thresh: got v=%b da=%b, want 0 0", evt_valid, drag_active);
        end
        xpos_in = 12'd205;
        ticks(2);
        vectors++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_x !== 12'd200 || evt_y !== 12'd150 || drag_active !== 1'b1) begin
            miscompares++;
            $display("FAIL drag_start: got v=%b t=%b (%0d,%0d) da=%b, want 1 01 (200,150) 1",
                     evt_valid, evt_type, evt_x, evt_y, drag_active);
        end
        xpos_in = 12'd300; ypos_in = 12'd220; left_in = 1'b0;
        tick();
        wait_valid(40, cyc);
        vectors++;
        if (cyc !== 17 || evt_type !== 2'b10 || evt_x !== 12'd300 || evt_y !== 12'd220 || drag_active !== 1'b0) begin
            miscompares++;
            $display("FAIL drag_end: got cyc=%0d t=%b (%0d,%0d) da=%b, want 17 10 (300,220) 0",
                     cyc, evt_type, evt_x, evt_y, drag_active);
        end
        tick();
    endtask
`else
    task automatic test_no_drag();
        int cyc;
        int da;
        da = 0;
        xpos_in = 12'd200; ypos_in = 12'd150; evt_ready = 1'b1;
        ticks(2);
        left_in = 1'b1;
        for (int i = 0; i < 22; i++) begin tick(); if (drag_active || evt_valid) da++; end
        xpos_in = 12'd400; ypos_in = 12'd300;
        for (int i = 0; i < 10; i++) begin tick(); if (drag_active || evt_valid) da++; end
        vectors++;
        if (da !== 0) begin
            miscompares++;
            $display("FAIL nodrag_quiet: got %0d active cycles, want 0", da);
        end
        left_in = 1'b0;
        wait_valid(40, cyc);
        vectors++;
        if (cyc !== 18 || evt_type !== 2'b00 || evt_x !== 12'd200 || evt_y !== 12'd150 || drag_active !== 1'b0) begin
            miscompares++;
            $display("FAIL nodrag_click: got cyc=%0d t=%b (%0d,%0d) da=%b, want 18 00 (200,150) 0",
                     cyc, evt_type, evt_x, evt_y, drag_active);
        end
        tick();
    endtask
`endif

    task automatic test_back_to_back();
        int cyc;
        int drops;
        int drop_at;
        int unstable;
        evt_ready = 1'b0;
        xpos_in = 12'd10; ypos_in = 12'd20;
        ticks(2);
        left_in = 1'b1; ticks(25);
        left_in = 1'b0;
        wait_valid(40, cyc);
        vectors++;
        if (cyc !== 18 || evt_type !== 2'b00 || evt_x !== 12'd10 || evt_y !== 12'd20) begin
            miscompares++;
            $display("FAIL bp_first: got cyc=%0d t=%b (%0d,%0d), want 18 00 (10,20)", cyc, evt_type, evt_x, evt_y);
        end
        drops = 0; drop_at = -1; unstable = 0;
        xpos_in = 12'd30; ypos_in = 12'd40;
        for (int i = 0; i < 2; i++) begin tick(); if (evt_drop) drops++; end
        left_in = 1'b1;
        for (int i = 0; i < 25; i++) begin tick(); if (evt_drop) drops++; end
        left_in = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (evt_drop) begin drops++; drop_at = i; end
            if (!evt_valid || evt_type !== 2'b00 || evt_x !== 12'd10 || evt_y !== 12'd20) unstable++;
        end
        vectors++;
        if (drops !== 1 || drop_at !== 18) begin
            miscompares++;
            $display("FAIL bp_drop: got %0d pulses at edge %0d, want 1 at 18", drops, drop_at);
        end
        vectors++;
        if (unstable !== 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d unstable cycles, want 0", unstable);
        end
        evt_ready = 1'b1;
        tick();
        vectors++;
        if (evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b, want 0", evt_valid);
        end
    endtask

    task automatic test_mid_reset();
        int seen;
        seen = 0;
        evt_ready = 1'b0;
        xpos_in = 12'd500; ypos_in = 12'd400;
        ticks(2);
        left_in = 1'b1;
        ticks(22);
        xpos_in = 12'd520;
        ticks(3);
`ifdef MOUSE_DRAG_EN
        vectors++;
        if (drag_active !== 1'b1 || evt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: got da=%b v=%b, want 1 1", drag_active, evt_valid);
        end
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1; left_in = 1'b0;
        vectors++;
        if (drag_active !== 1'b0 || evt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got da=%b v=%b, want 0 0", drag_active, evt_valid);
        end
        for (int i = 0; i < 40; i++) begin tick(); if (evt_valid || drag_active || evt_drop) seen++; end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL mid_release: got %0d active cycles, want 0", seen);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; xpos_in = 12'd0; ypos_in = 12'd0; left_in = 1'b0; evt_ready = 1'b0;
        test_reset();
        test_glitch();
        test_click();
`ifdef MOUSE_DRAG_EN
        test_drag();
`else
        test_no_drag();
`endif
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
